// File: rtl/counter_pkg.sv
// Shared constants and parameter helpers for the up/down counter family.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Legal when 1 <= WIDTH <= 32, 2 <= MODULO <= 2^WIDTH and SATURATE is a known mode.
    function automatic bit params_ok(input int width, input int modulo, input int saturate);
        longint span;
        if (width < 1 || width > 32) return 1'b0;
        span = longint'(1) << width;
        return (modulo >= 2) && (longint'(modulo) <= span) &&
               (saturate == MODE_WRAP || saturate == MODE_SAT);
    endfunction

endpackage

// File: rtl/counter_next.sv
// Next-count decode for updown_counter_mod: load clamp, wrap/saturate and cascade outputs.
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             load_i,
    input  logic             up_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] par_in_i,
    output logic [WIDTH-1:0] next_o,
    output logic             event_o,
    output logic             carry_o,
    output logic             borrow_o
);

    // One extra bit so MODULO == 2^WIDTH and non-power-of-two ranges never rely on rollover.
    localparam logic [WIDTH:0] MAX_CNT = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);
    localparam bit             SAT_EN  = (SATURATE == MODE_SAT);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] par_ext;
    logic [WIDTH:0] next_ext;
    logic           up_only;
    logic           down_only;
    logic           at_max;
    logic           at_min;

    assign cnt_ext   = {1'b0, cnt_i};
    assign par_ext   = {1'b0, par_in_i};
    assign up_only   = up_i & ~down_i;
    assign down_only = down_i & ~up_i;
    assign at_max    = (cnt_ext == MAX_CNT);
    assign at_min    = (cnt_ext == '0);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        next_ext = cnt_ext;
        event_o  = 1'b0;
        if (load_i) begin
            next_ext = (par_ext > MAX_CNT) ? MAX_CNT : par_ext;
        end else if (up_only) begin
            if (at_max) begin
                event_o  = 1'b1;
                next_ext = SAT_EN ? MAX_CNT : '0;
            end else begin
                next_ext = cnt_ext + ONE;
            end
        end else if (down_only) begin
            if (at_min) begin
                event_o  = 1'b1;
                next_ext = SAT_EN ? '0 : MAX_CNT;
            end else begin
                next_ext = cnt_ext - ONE;
            end
        end
    end

    assign next_o   = next_ext[WIDTH-1:0];
    assign carry_o  = up_only   & ~load_i & at_max;
    assign borrow_o = down_only & ~load_i & at_min;

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter: state register, sticky overflow and reset gating around counter_next.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             up_cnt_en,
    input  logic             down_cnt_en,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] par_out,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             zero,
    output logic             ovf_sticky
);

    if (!params_ok(WIDTH, MODULO, SATURATE)) begin : g_bad_params
        $error("updown_counter_mod: illegal WIDTH/MODULO/SATURATE combination");
    end

    logic [WIDTH-1:0] par_q;
    logic [WIDTH-1:0] par_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             wrap_event;
    logic             carry_raw;
    logic             borrow_raw;

    counter_next #(
        .WIDTH    (WIDTH),
        .MODULO   (MODULO),
        .SATURATE (SATURATE)
    ) u_next (
        .cnt_i    (par_q),
        .load_i   (load),
        .up_i     (up_cnt_en),
        .down_i   (down_cnt_en),
        .par_in_i (par_in),
        .next_o   (par_d),
        .event_o  (wrap_event),
        .carry_o  (carry_raw),
        .borrow_o (borrow_raw)
    );

    // Load clears the sticky flag; otherwise any wrap or saturation attempt sets it.
    assign ovf_d = load ? 1'b0 : (ovf_q | wrap_event);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            par_q <= par_d;
            ovf_q <= ovf_d;
        end
    end

    assign par_out    = par_q;
    assign ovf_sticky = ovf_q;
    assign zero       = (par_q == '0);
    assign carry_out  = rst & carry_raw;
    assign borrow_out = rst & borrow_raw;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench: wrap and saturate counters (WIDTH=4, MODULO=10) driven in lockstep, plus a two-digit cascade.
module tb_updown_counter_mod;

    localparam int MOD = 10;

    typedef struct {
        int dut;
        int cnt;
        bit ovf;
        bit chk_ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, load, up, down;
    logic [3:0] par_in;
    logic       c_rst, c_load, c_en;

    // Index 0: wrap, 1: saturate, 2: cascade low digit, 3: cascade high digit.
    logic [3:0] par_w   [4];
    logic       carry_w [4];
    logic       borrow_w[4];
    logic       zero_w  [4];
    logic       ovf_w   [4];

    updown_counter_mod #(.WIDTH(4), .MODULO(MOD), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .load(load), .up_cnt_en(up), .down_cnt_en(down),
        .par_in(par_in), .par_out(par_w[0]), .carry_out(carry_w[0]),
        .borrow_out(borrow_w[0]), .zero(zero_w[0]), .ovf_sticky(ovf_w[0])
    );

    updown_counter_mod #(.WIDTH(4), .MODULO(MOD), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .load(load), .up_cnt_en(up), .down_cnt_en(down),
        .par_in(par_in), .par_out(par_w[1]), .carry_out(carry_w[1]),
        .borrow_out(borrow_w[1]), .zero(zero_w[1]), .ovf_sticky(ovf_w[1])
    );

    updown_counter_mod #(.WIDTH(4), .MODULO(MOD), .SATURATE(0)) u_lo (
        .clk(clk), .rst(c_rst), .load(c_load), .up_cnt_en(c_en), .down_cnt_en(1'b0),
        .par_in(4'd0), .par_out(par_w[2]), .carry_out(carry_w[2]),
        .borrow_out(borrow_w[2]), .zero(zero_w[2]), .ovf_sticky(ovf_w[2])
    );

    updown_counter_mod #(.WIDTH(4), .MODULO(MOD), .SATURATE(0)) u_hi (
        .clk(clk), .rst(c_rst), .load(c_load), .up_cnt_en(carry_w[2]), .down_cnt_en(1'b0),
        .par_in(4'd0), .par_out(par_w[3]), .carry_out(carry_w[3]),
        .borrow_out(borrow_w[3]), .zero(zero_w[3]), .ovf_sticky(ovf_w[3])
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    int m_cnt[2];
    bit m_ovf[2];
    int c_total;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic drain(input string what);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("%s par%0d", what, e.dut), 32'(par_w[e.dut]), 32'(e.cnt));
            check($sformatf("%s zero%0d", what, e.dut), 32'(zero_w[e.dut]), 32'(e.cnt == 0));
            if (e.chk_ovf)
                check($sformatf("%s ovf%0d", what, e.dut), 32'(ovf_w[e.dut]), 32'(e.ovf));
        end
    endtask

    // Drives one edge of stimulus into the wrap and saturate counters together.
    task automatic step(input string what, input logic r, l, u, d, input logic [3:0] p);
        bit exp_c, exp_b;
        @(negedge clk);
        rst = r; load = l; up = u; down = d; par_in = p;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_c = r && u && !d && !l && (m_cnt[k] == MOD - 1);
            exp_b = r && d && !u && !l && (m_cnt[k] == 0);
            check($sformatf("%s carry%0d", what, k), 32'(carry_w[k]), 32'(exp_c));
            check($sformatf("%s borrow%0d", what, k), 32'(borrow_w[k]), 32'(exp_b));
            if (!r) begin
                m_cnt[k] = 0;
                m_ovf[k] = 1'b0;
            end else if (l) begin
                m_cnt[k] = (int'(p) > MOD - 1) ? MOD - 1 : int'(p);
                m_ovf[k] = 1'b0;
            end else if (u && !d) begin
                if (m_cnt[k] == MOD - 1) begin
                    m_ovf[k] = 1'b1;
                    m_cnt[k] = (k == 1) ? MOD - 1 : 0;
                end else m_cnt[k]++;
            end else if (d && !u) begin
                if (m_cnt[k] == 0) begin
                    m_ovf[k] = 1'b1;
                    m_cnt[k] = (k == 1) ? 0 : MOD - 1;
                end else m_cnt[k]--;
            end
            sb.push_back('{k, m_cnt[k], m_ovf[k], 1'b1});
        end
        @(posedge clk);
        #1;
        drain(what);
    endtask

    task automatic cstep(input string what, input logic r, l, en);
        @(negedge clk);
        c_rst = r; c_load = l; c_en = en;
        if (!r || l) c_total = 0;
        else if (en) c_total++;
        sb.push_back('{2, c_total % MOD, 1'b0, 1'b0});
        sb.push_back('{3, (c_total / MOD) % MOD, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        drain(what);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; load = 1'b0; up = 1'b1; down = 1'b1; par_in = '0;
        c_rst = 1'b0; c_load = 1'b0; c_en = 1'b0;
        m_cnt = '{0, 0}; m_ovf = '{1'b0, 1'b0}; c_total = 0;

        step("rst",      0, 0, 1, 1, 4'd0);
        step("rst",      0, 0, 1, 1, 4'd0);

        step("ld8",      1, 1, 0, 0, 4'd8);
        repeat (3) step("up", 1, 0, 1, 0, 4'd0);

        step("ld1",      1, 1, 0, 0, 4'd1);
        repeat (2) step("down", 1, 0, 0, 1, 4'd0);
        step("both",     1, 0, 1, 1, 4'd0);
        step("none",     1, 0, 0, 0, 4'd0);

        step("ld9",      1, 1, 0, 0, 4'd9);
        repeat (2) step("up_end", 1, 0, 1, 0, 4'd0);
        step("ld0",      1, 1, 0, 0, 4'd0);
        step("down_end", 1, 0, 0, 1, 4'd0);

        step("clamp",    1, 1, 1, 0, 4'd13);
        step("ldmax",    1, 1, 0, 1, 4'd15);
        step("up_mid",   1, 0, 1, 0, 4'd0);
        step("ld3",      1, 1, 0, 0, 4'd3);
        step("up_mid",   1, 0, 1, 0, 4'd0);
        step("rst_mid",  0, 0, 1, 0, 4'd0);
        step("after",    1, 0, 0, 0, 4'd0);

        cstep("c_rst", 0, 0, 1);
        repeat (25) cstep("c_up", 1, 0, 1);
        cstep("c_hold", 1, 0, 0);
        check("cascade_lo", 32'(par_w[2]), 32'd5);
        check("cascade_hi", 32'(par_w[3]), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised synchronous up/down counter with parallel load, programmable modulus, wrap or saturate end behaviour, cascade carry/borrow outputs and a sticky overflow flag. It is the general-purpose successor to the fixed 4-bit up/down counter. Datapath blocks instantiate it directly for loop indices, timers and BCD-style digit chains, cascading instances through `carry_out`/`borrow_out`.

## Interface
- `WIDTH`, default 4: counter width in bits; must be ≥ 1.
- `MODULO`, default 16: count range is 0 … MODULO-1; 2 ≤ MODULO ≤ 2^WIDTH.
- `SATURATE`, default 0: 0 selects wrap mode, 1 selects saturate mode.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, **synchronous, active-low**.
- `load`  in  1: parallel load strobe.
- `up_cnt_en`  in  1: count-up enable.
- `down_cnt_en`  in  1: count-down enable.
- `par_in`  in  WIDTH: parallel load value.
- `par_out`  out  WIDTH: registered count value.
- `carry_out`  out  1: combinational; asserted when `up_cnt_en` is high, `down_cnt_en` is low, `load` is low and `par_out` == MODULO-1.
- `borrow_out`  out  1: combinational; asserted when `down_cnt_en` is high, `up_cnt_en` is low, `load` is low and `par_out` == 0.
- `zero`  out  1: combinational; `par_out` == 0.
- `ovf_sticky`  out  1: registered; set by any wrap or saturation event.

## Operation
- **Per-edge priority:** reset > load > count > hold.
- **Reset** (`rst`=0 at an edge): `par_out`=0, `ovf_sticky`=0. `carry_out` and `borrow_out` are forced to 0 while `rst`=0.
- **Load:** `par_out` ← `par_in`. If `par_in` ≥ MODULO, the loaded value is clamped to MODULO-1. Load clears `ovf_sticky`. Load ignores the count enables.
- **Count direction:**
  - Up only (`up_cnt_en`=1, `down_cnt_en`=0): `par_out`+1.
  - Down only (`down_cnt_en`=1, `up_cnt_en`=0): `par_out`-1.
  - Both enables high, or neither: hold.
- **Wrap mode (SATURATE=0):**
  - Up at MODULO-1 → 0.
  - Down at 0 → MODULO-1.
  - Either transition sets `ovf_sticky`.
- **Saturate mode (SATURATE=1):**
  - Up at MODULO-1 holds MODULO-1.
  - Down at 0 holds 0.
  - Either attempt sets `ovf_sticky`.
- `carry_out`/`borrow_out` behave identically in both modes. They are a pure decode of the current state and enables, so they cascade within the same cycle: a higher digit's `up_cnt_en` is driven from the lower digit's `carry_out`.
- **Arithmetic:** next-value computed at WIDTH+1 bits internally, with no reliance on natural 2^WIDTH overflow. This keeps non-power-of-two MODULO values correct.
- `ovf_sticky` persists until reset or load.

## Timing
- Load and count latency: 1 cycle. The value is visible on `par_out` after the edge at which the request is sampled.
- `carry_out`, `borrow_out` and `zero` have zero latency. They are valid in the same cycle as their inputs, with no registered delay.
- `ovf_sticky` rises on the same edge that performs the wrap or saturation.
- **Reset mid-count:** the count is discarded on that edge and there is no partial update. Enables sampled on the reset edge are ignored.
- **Load and end-of-range count in the same cycle:** load wins, and `carry_out`/`borrow_out` are 0 that cycle.
- **Reset values:**
  - `par_out`=0, `ovf_sticky`=0, `zero`=1.
  - `carry_out`=0, `borrow_out`=0.

## Structure
- Shared package `counter_pkg` holds:
  - `MODE_WRAP`=0 and `MODE_SAT`=1 constants.
  - A width-check helper function used in parameter assertions.
- One combinational sub-module, `counter_next`, takes `par_out`, the enables, `load`, `par_in`, MODULO and SATURATE. It returns:
  - the next count;
  - a wrap/saturate event bit;
  - `carry_out`;
  - `borrow_out`.
- The top level holds only the state register, the `ovf_sticky` register and the reset gating.
- Elaboration-time assertions check WIDTH ≥ 1 and 2 ≤ MODULO ≤ 2^WIDTH.

## Test plan
All scenarios use WIDTH=4, MODULO=10 unless stated.
- **Reset:** `rst`=0 for 2 edges with both enables high → `par_out`=0, `zero`=1, `carry_out`=0, `ovf_sticky`=0.
- **Wrap up:** load 8, then `up_cnt_en`=1 for 3 edges → `par_out` 9, 0, 1. `carry_out`=1 only while `par_out`=9. `ovf_sticky`=1 after the 9→0 edge.
- **Wrap down, simultaneous enables:** load 1, down for 2 edges → 0 then 9. `borrow_out`=1 while at 0. Both enables high → `par_out` holds 9.
- **Saturate** (SATURATE=1): load 9, up for 2 edges → `par_out` stays 9 and `ovf_sticky`=1. Load 0 clears `ovf_sticky`. Down → stays 0 and `ovf_sticky` sets again.
- **Load clamp and priority:** `par_in`=13 with `load`=1 and `up_cnt_en`=1 → `par_out`=9, `carry_out`=0 that cycle. Then `rst`=0 mid-count → `par_out`=0 next edge.
- **Cascade:** two instances, low digit's `carry_out` driving high digit's `up_cnt_en`. 25 up-counts from 0 → high=2, low=5.
